// File: rtl/wdt_controller_pkg.sv
// Shared definitions for the watchdog timer: bus widths, register map,
// CTRL bit positions, feed key, FSM state codes and core command bundle.
package wdt_controller_pkg;

   localparam int WDT_VA_WIDTH  = 4;
   localparam int BUS_WIDTH     = 32;
   localparam int BUS_ACC_WIDTH = 2;

   // acc encodes the access size in bytes as log2
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_1B = 2'd0;
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_2B = 2'd1;
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = 2'd2;

   localparam logic [WDT_VA_WIDTH-1:0] WDT_CTRL = 4'd0;
   localparam logic [WDT_VA_WIDTH-1:0] WDT_LOAD = 4'd4;
   localparam logic [WDT_VA_WIDTH-1:0] WDT_FEED = 4'd8;
   localparam logic [WDT_VA_WIDTH-1:0] WDT_CNT  = 4'd12;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_LOCK = 1;
   localparam int CTRL_WIE  = 2;
   localparam int CTRL_WDRF = 7;

   localparam logic [7:0] WDT_FEED_KEY  = 8'hA5;
   localparam logic [7:0] CTRL_W1C_ONLY = 8'h80;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_BITE = 2'd2;

   typedef struct packed {
      logic start;
      logic stop;
      logic feed_ok;
      logic feed_bad;
   } wdt_cmd_t;

endpackage

// File: rtl/wdt_core.sv
// Watchdog FSM: countdown counter, bite detection and the fixed-length
// reset pulse. Driven by one-cycle strobes from the bus decode.
module wdt_core
   import wdt_controller_pkg::*;
#(
   parameter logic [31:0] LOAD_DEFAULT = 32'd50_000_000,
   parameter int          PULSE_LEN    = 4
) (
   input  logic        clk,
   input  logic        rst_ib,
   input  wdt_cmd_t    cmd,
   input  logic [31:0] load_val,
   output logic [1:0]  state,
   output logic [31:0] cnt,
   output logic        bite_done,
   output logic        rst_o
);

   localparam logic [7:0] PLEN = 8'(PULSE_LEN);

   logic [7:0] pcnt;

   assign bite_done = (state == S_BITE) && (pcnt == PLEN);

   // State, counter and pulse sequencing; a good feed beats CNT==0
   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib) begin
         state <= S_IDLE;
         cnt   <= LOAD_DEFAULT;
         pcnt  <= '0;
         rst_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd.start) begin
                  cnt   <= load_val;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (cmd.stop)
                  state <= S_IDLE;
               else if (cmd.feed_bad)
                  state <= S_BITE;
               else if (cmd.feed_ok)
                  cnt <= load_val;
               else if (cnt == '0)
                  state <= S_BITE;
               else
                  cnt <= cnt - 32'd1;
            end
            S_BITE: begin
               if (bite_done) begin
                  state <= S_IDLE;
                  rst_o <= 1'b0;
                  pcnt  <= '0;
                  cnt   <= load_val;
               end else begin
                  rst_o <= 1'b1;
                  pcnt  <= pcnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/wdt_controller.sv
// Watchdog timer bus slave: access checking, CTRL/LOAD registers, responses.
// Define WDT_WARN_EN to add the WIE bit and the early-warning irq output.
module wdt_controller
   import wdt_controller_pkg::*;
#(
   parameter logic [31:0] LOAD_DEFAULT = 32'd50_000_000,
   parameter int          PULSE_LEN    = 4
`ifdef WDT_WARN_EN
   ,
   parameter int          WARN_CNT     = 1024
`endif
) (
   input  logic                     clk,
   input  logic                     rst_ib,
   output logic                     rst_o,
   input  logic [WDT_VA_WIDTH-1:0]  addr,
   input  logic                     w_rb,
   input  logic [BUS_ACC_WIDTH-1:0] acc,
   output logic [BUS_WIDTH-1:0]     rdata,
   input  logic [BUS_WIDTH-1:0]     wdata,
   input  logic                     req,
   output logic                     resp,
   output logic                     fault
`ifdef WDT_WARN_EN
   ,
   output logic                     irq
`endif
);

   logic        en, lock, wie, wdrf;
   logic [31:0] load, cnt, rd_val;
   logic [1:0]  state;
   logic        bite_done;
   logic        hit_ctrl, hit_load, hit_feed, hit_cnt;
   logic        bad, ok, ctrl_wr, load_wr, feed_wr, key_ok;
   wdt_cmd_t    cmd;

   assign hit_ctrl = (addr == WDT_CTRL);
   assign hit_load = (addr == WDT_LOAD);
   assign hit_feed = (addr == WDT_FEED);
   assign hit_cnt  = (addr == WDT_CNT);

   // Under LOCK the only CTRL write allowed is exactly the WDRF clear
   always_comb begin
      bad = 1'b1;
      unique case (1'b1)
         hit_ctrl: bad = (acc != ACC_1B) ||
                         (w_rb && lock && (wdata[7:0] != CTRL_W1C_ONLY));
         hit_load: bad = (acc != ACC_4B) ||
                         (w_rb && (lock || (wdata == '0)));
         hit_feed: bad = (acc != ACC_1B) || !w_rb;
         hit_cnt:  bad = (acc != ACC_4B) || w_rb;
         default:  bad = 1'b1;
      endcase
   end

   assign fault   = req & bad;
   assign ok      = req & ~bad;
   assign ctrl_wr = ok & w_rb & hit_ctrl;
   assign load_wr = ok & w_rb & hit_load;
   assign feed_wr = ok & w_rb & hit_feed;
   assign key_ok  = (wdata[7:0] == WDT_FEED_KEY);

   // Core strobes; feeds only matter while running
   always_comb begin
      cmd.start    = ctrl_wr & ~lock & wdata[CTRL_EN] & (state == S_IDLE);
      cmd.stop     = ctrl_wr & ~lock & ~wdata[CTRL_EN] & (state == S_RUN);
      cmd.feed_ok  = feed_wr & key_ok & (state == S_RUN);
      cmd.feed_bad = feed_wr & ~key_ok & (state == S_RUN);
   end

   // Read data selection, unused bits zero
   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         hit_ctrl: rd_val[7:0] = {wdrf, 4'b0000, wie, lock, en};
         hit_load: rd_val = load;
         hit_cnt:  rd_val = cnt;
         default:  rd_val = '0;
      endcase
   end

   // CTRL/LOAD storage; end of a bite overrides same-cycle writes
   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib) begin
         en   <= 1'b0;
         lock <= 1'b0;
         wdrf <= 1'b0;
         load <= LOAD_DEFAULT;
      end else begin
         if (ctrl_wr && !lock && (state != S_BITE))
            en <= wdata[CTRL_EN];
         if (ctrl_wr && wdata[CTRL_LOCK])
            lock <= 1'b1;
         if (ctrl_wr && wdata[CTRL_WDRF])
            wdrf <= 1'b0;
         if (load_wr)
            load <= wdata;
         if (bite_done) begin
            en   <= 1'b0;
            lock <= 1'b0;
            wdrf <= 1'b1;
         end
      end
   end

`ifdef WDT_WARN_EN
   // WIE is frozen by LOCK like the other control bits
   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib)
         wie <= 1'b0;
      else if (ctrl_wr && !lock)
         wie <= wdata[CTRL_WIE];
   end

   // Early warning while running close to expiry
   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib)
         irq <= 1'b0;
      else
         irq <= wie && (state == S_RUN) && (cnt <= 32'(WARN_CNT));
   end
`else
   assign wie = 1'b0;
`endif

   // One-cycle response with read data for accepted accesses
   always_ff @(posedge clk or negedge rst_ib) begin
      if (!rst_ib) begin
         resp  <= 1'b0;
         rdata <= '0;
      end else begin
         resp  <= ok;
         rdata <= (ok && !w_rb) ? rd_val : '0;
      end
   end

   wdt_core #(
      .LOAD_DEFAULT (LOAD_DEFAULT),
      .PULSE_LEN    (PULSE_LEN)
   ) u_core (
      .clk       (clk),
      .rst_ib    (rst_ib),
      .cmd       (cmd),
      .load_val  (load),
      .state     (state),
      .cnt       (cnt),
      .bite_done (bite_done),
      .rst_o     (rst_o)
   );

endmodule

// File: tb/tb_wdt_controller.sv
// Bench for wdt_controller: directed scenarios with literal expectations
// plus randomized bus traffic checked each cycle against a reference model.
module tb_wdt_controller;

   localparam int          PL   = 4;
   localparam logic [31:0] LD   = 32'd50_000_000;
   localparam int          WARN = 4;
   localparam int MI = 0, MR = 1, MB = 2;

   logic        clk = 1'b0, rst_ib = 1'b1;
   logic        rst_o, resp, fault;
   logic        w_rb = 1'b0, req = 1'b0;
   logic [3:0]  addr = '0;
   logic [1:0]  acc = '0;
   logic [31:0] rdata, wdata = '0;
`ifdef WDT_WARN_EN
   logic        irq;
`endif

   int vectors = 0, miscompares = 0;

   wdt_controller #(
      .LOAD_DEFAULT (LD),
      .PULSE_LEN    (PL)
`ifdef WDT_WARN_EN
      ,
      .WARN_CNT     (WARN)
`endif
   ) dut (
      .clk    (clk),
      .rst_ib (rst_ib),
      .rst_o  (rst_o),
      .addr   (addr),
      .w_rb   (w_rb),
      .acc    (acc),
      .rdata  (rdata),
      .wdata  (wdata),
      .req    (req),
      .resp   (resp),
      .fault  (fault)
`ifdef WDT_WARN_EN
      ,
      .irq    (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model state: what the watchdog must hold after each edge
   int          m_mode = MI, m_age = 0;
   logic [31:0] m_cnt = LD, m_load = LD, m_rdata = '0;
   logic        m_en = 0, m_lock = 0, m_wie = 0, m_wdrf = 0;
   logic        m_rst = 0, m_resp = 0, m_irq = 0;

   function automatic logic exp_bad();
      case (addr)
         4'd0:  return acc != 2'd0 ||
                       (w_rb && m_lock && wdata[7:0] != 8'h80);
         4'd4:  return acc != 2'd2 || (w_rb && (m_lock || wdata == 0));
         4'd8:  return acc != 2'd0 || !w_rb;
         4'd12: return acc != 2'd2 || w_rb;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] reg_read();
      case (addr)
         4'd0:  return {24'd0, m_wdrf, 4'd0, m_wie, m_lock, m_en};
         4'd4:  return m_load;
         4'd12: return m_cnt;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_ib) begin : model
      logic        okk, cw, fw, lw, done, o_lock;
      logic [31:0] o_load, o_cnt;
      int          o_mode;
      if (!rst_ib) begin
         m_mode = MI; m_age = 0; m_cnt = LD; m_load = LD; m_rdata = 0;
         m_en = 0; m_lock = 0; m_wie = 0; m_wdrf = 0;
         m_rst = 0; m_resp = 0; m_irq = 0;
      end else begin
         okk = req && !exp_bad();
         cw = okk && w_rb && addr == 4'd0;
         fw = okk && w_rb && addr == 4'd8;
         lw = okk && w_rb && addr == 4'd4;
         o_load = m_load; o_cnt = m_cnt; o_mode = m_mode; o_lock = m_lock;
         done = 0;
`ifdef WDT_WARN_EN
         m_irq = m_wie && o_mode == MR && o_cnt <= WARN;
`endif
         m_resp  = okk;
         m_rdata = (okk && !w_rb) ? reg_read() : 32'd0;
         if (o_mode == MI) begin
            if (cw && !o_lock && wdata[0]) begin
               m_mode = MR; m_cnt = o_load;
            end
         end else if (o_mode == MR) begin
            if (cw && !o_lock && !wdata[0]) m_mode = MI;
            else if (fw && wdata[7:0] == 8'hA5) m_cnt = o_load;
            else if (fw || o_cnt == 0) begin m_mode = MB; m_age = 0; end
            else m_cnt = o_cnt - 1;
         end else begin
            if (m_age < PL) begin m_age++; m_rst = 1; end
            else done = 1;
         end
         if (cw) begin
            if (!o_lock) begin
               if (o_mode != MB) m_en = wdata[0];
               if (wdata[1]) m_lock = 1;
`ifdef WDT_WARN_EN
               m_wie = wdata[2];
`endif
               if (wdata[7]) m_wdrf = 0;
            end else begin
               m_wdrf = 0;
            end
         end
         if (lw) m_load = wdata;
         if (done) begin
            m_en = 0; m_lock = 0; m_wdrf = 1; m_cnt = o_load;
            m_mode = MI; m_rst = 0;
         end
      end
   end

   // Every cycle: registered outputs and combinational fault vs model
   always @(negedge clk) begin
      chk("rst_o", rst_o, m_rst);
      chk("resp", resp, m_resp);
      chk("rdata", rdata, m_rdata);
      chk("fault", fault, req && exp_bad());
`ifdef WDT_WARN_EN
      chk("irq", irq, m_irq);
`endif
   end

   task automatic bus(input logic w, input logic [3:0] a, input logic [1:0] s,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic f, output logic r);
      @(posedge clk); #2;
      req = 1; w_rb = w; addr = a; acc = s; wdata = d;
      #1 f = fault;
      @(posedge clk); #2;
      req = 0; w_rb = 0; addr = 0; acc = 0; wdata = 0;
      rd = rdata; r = resp;
   endtask

   task automatic wait_rst(input logic lvl, input int max, output int n);
      n = 0;
      while (rst_o !== lvl && n < max) begin
         @(posedge clk); #2; n++;
      end
   endtask

   task automatic high_len(output int w);
      w = 0;
      while (rst_o === 1'b1 && w < 100) begin
         w++; @(posedge clk); #2;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        f, r;
      int          n, w, highs, sel;
      #1 rst_ib = 0;
      repeat (3) @(posedge clk);
      #3 rst_ib = 1;

      bus(0, 0, 0, 0, rd, f, r);  chk("reset_ctrl", rd, 0);
      bus(0, 4, 2, 0, rd, f, r);  chk("reset_load", rd, 50_000_000);
      bus(0, 12, 2, 0, rd, f, r); chk("reset_cnt", rd, 50_000_000);
      chk("reset_rst_o", rst_o, 0);

      bus(1, 4, 2, 10, rd, f, r);
      bus(1, 0, 0, 1, rd, f, r);  chk("en_resp", r, 1);
      wait_rst(1, 100, n);        chk("bite_delay", n, 12);
      high_len(w);                chk("pulse_len", w, 4);
      bus(0, 0, 0, 0, rd, f, r);  chk("ctrl_after_bite", rd, 8'h80);
      bus(0, 12, 2, 0, rd, f, r); chk("cnt_after_bite", rd, 10);

      bus(1, 0, 0, 8'h81, rd, f, r);
      highs = 0;
      for (int k = 0; k < 12; k++) begin
         bus(1, 8, 0, 8'hA5, rd, f, r);
         repeat (6) begin
            @(posedge clk); #2;
            if (rst_o === 1'b1) highs++;
         end
      end
      chk("fed_no_bite", highs, 0);
      bus(1, 8, 0, 8'hA5, rd, f, r);
      bus(0, 12, 2, 0, rd, f, r); chk("cnt_after_feed", rd, 9);

      bus(1, 8, 0, 8'h5A, rd, f, r);
      chk("bad_feed_gap", rst_o, 0);
      @(posedge clk); #2;
      chk("bad_feed_rise", rst_o, 1);
      high_len(w);                chk("bad_feed_pulse", w, 4);

      bus(1, 4, 2, 40, rd, f, r);
      bus(1, 0, 0, 8'h03, rd, f, r); chk("lock_resp", r, 1);
      bus(1, 4, 2, 5, rd, f, r);
      chk("locked_load_fault", f, 1); chk("locked_load_resp", r, 0);
      bus(0, 4, 2, 0, rd, f, r);  chk("load_unchanged", rd, 40);
      bus(1, 0, 0, 8'h80, rd, f, r);
      chk("w1c_fault", f, 0);     chk("w1c_resp", r, 1);
      bus(0, 0, 0, 0, rd, f, r);  chk("ctrl_locked", rd, 8'h03);
      wait_rst(1, 100, n);
      wait_rst(0, 100, n);
      bus(0, 0, 0, 0, rd, f, r);  chk("unlock_after_bite", rd, 8'h80);

      bus(0, 0, 1, 0, rd, f, r);
      chk("f_2b_ctrl", f, 1);     chk("r_2b_ctrl", r, 0);
      bus(1, 12, 2, 7, rd, f, r);
      chk("f_wr_cnt", f, 1);      chk("r_wr_cnt", r, 0);
      bus(0, 8, 0, 0, rd, f, r);
      chk("f_rd_feed", f, 1);     chk("r_rd_feed", r, 0);
      bus(0, 3, 0, 0, rd, f, r);
      chk("f_unmapped", f, 1);    chk("r_unmapped", r, 0);
      bus(1, 4, 2, 0, rd, f, r);
      chk("f_load_zero", f, 1);

`ifdef WDT_WARN_EN
      bus(1, 4, 2, 10, rd, f, r);
      bus(1, 0, 0, 8'h05, rd, f, r);
      n = 0;
      while (irq !== 1'b1 && n < 50) begin @(posedge clk); #2; n++; end
      chk("irq_rise", n, 7);
      bus(1, 8, 0, 8'hA5, rd, f, r);
      @(posedge clk); #2;
      chk("irq_clear", irq, 0);
      bus(1, 0, 0, 8'h00, rd, f, r);
`endif

      bus(1, 4, 2, 3, rd, f, r);
      bus(1, 0, 0, 8'h01, rd, f, r);
      wait_rst(1, 50, n);
      chk("abort_pre", rst_o, 1);
      @(posedge clk); #3 rst_ib = 0;
      #1 chk("abort_rst_o", rst_o, 0);
      #4 rst_ib = 1;
      bus(0, 0, 0, 0, rd, f, r);  chk("abort_wdrf", rd, 0);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if (i % 750 == 749) begin
            req = 0;
            #1 rst_ib = 0;
            #4 rst_ib = 1;
            continue;
         end
         req = 1;
         sel = $urandom_range(0, 15);
         case (sel)
            0, 1, 2, 3, 4: begin
               w_rb = 1; addr = 8; acc = 0;
               wdata = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                                    : 32'hA5;
            end
            5, 6: begin
               w_rb = 1; addr = 0; acc = 0;
               case ($urandom_range(0, 6))
                  0: wdata = 8'h01;
                  1: wdata = 8'h00;
                  2: wdata = 8'h81;
                  3: wdata = 8'h80;
                  4: wdata = 8'h03;
                  5: wdata = 8'h05;
                  default: wdata = $urandom_range(0, 255);
               endcase
            end
            7:  begin w_rb = 1; addr = 4; acc = 2; wdata = $urandom_range(0, 23); end
            8:  begin w_rb = 0; addr = 0; acc = 0; wdata = 0; end
            9:  begin w_rb = 0; addr = 4; acc = 2; wdata = 0; end
            10: begin w_rb = 0; addr = 12; acc = 2; wdata = 0; end
            11: begin w_rb = 0; addr = 8; acc = 0; wdata = 0; end
            12: begin
               w_rb = 1'($urandom); addr = 4'($urandom);
               acc = 2'($urandom); wdata = $urandom;
            end
            default: req = 0;
         endcase
         if ($urandom_range(0, 9) == 0) acc = 2'($urandom);
      end
      @(posedge clk); #2;
      req = 0; w_rb = 0; addr = 0; acc = 0; wdata = 0;
      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
